// File: rtl/iob_pwm_deadtime_if.sv
// Bundle of control and gate-drive signals between the PWM core side and the
// dead-time stage. The master drives the PWM/control inputs, the slave
// (the dead-time block) drives the gate outputs and status.
interface iob_pwm_deadtime_if #(
  parameter int DT_W = 8
);
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dead_time;
  logic            fault_in;
  logic            fault_clr;
  logic            out_h;
  logic            out_l;
  logic            dt_active;
  logic            fault_latched;

  modport master (
    output en, pwm_in, dead_time, fault_in, fault_clr,
    input  out_h, out_l, dt_active, fault_latched
  );

  modport slave (
    input  en, pwm_in, dead_time, fault_in, fault_clr,
    output out_h, out_l, dt_active, fault_latched
  );
endinterface

// File: rtl/iob_pwm_deadtime.sv
// Complementary gate driver with programmable dead time and latched fault
// shutdown. A single-ended PWM is turned into a high-side/low-side pair that
// are never on together; every hand-over between the two sides passes through
// a both-off dead-time state lasting dead_time+1 cycles.
//
// Interface handshake: there is no valid/ready handshake on this block. All
// inputs except fault_in are level signals synchronous to clk and are sampled
// on every rising edge; fault_clr is a single-cycle pulse. fault_in is
// asynchronous and is synchronized internally.
module iob_pwm_deadtime #(
  parameter int DT_W     = 8,
  parameter int FLT_SYNC = 2
) (
  input  logic                clk,
  input  logic                rst,
  iob_pwm_deadtime_if.slave   bus,
  output logic [2:0]          dbg_state_o
);

  // Fewer than two flops would not protect against metastability.
  localparam int SYNC_N = (FLT_SYNC < 2) ? 2 : FLT_SYNC;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_H  = 3'd1,
    ST_H_ON  = 3'd2,
    ST_DT_L  = 3'd3,
    ST_L_ON  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DT_W-1:0]   cnt_q, cnt_d;
  logic              pwm_q;
  logic [SYNC_N-1:0] sync_q;
  logic              fault_s;
  logic              out_h_q, out_l_q, dt_active_q, fault_latched_q;

  assign fault_s = sync_q[SYNC_N-1];

  // Input capture: one register stage on pwm_in, synchronizer chain on fault_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_q  <= 1'b0;
      sync_q <= '0;
    end else begin
      pwm_q  <= bus.pwm_in;
      sync_q <= {sync_q[SYNC_N-2:0], bus.fault_in};
    end
  end

  // Next-state and counter decode; fault beats disable beats normal flow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fault_s) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      // A clear is honoured only once the synchronized fault has gone away.
      if (bus.fault_clr) state_d = ST_OFF;
    end else if (!bus.en) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          // Leaving OFF always goes through a fresh dead time.
          state_d = pwm_q ? ST_DT_H : ST_DT_L;
          cnt_d   = bus.dead_time;
        end
        ST_DT_H: begin
          if (!pwm_q) begin
            // Pulse shorter than the dead time: high side never turns on.
            state_d = ST_L_ON;
          end else if (cnt_q == '0) begin
            state_d = ST_H_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DT_L: begin
          if (pwm_q) begin
            state_d = ST_H_ON;
          end else if (cnt_q == '0) begin
            state_d = ST_L_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_H_ON: begin
          if (!pwm_q) begin
            state_d = ST_DT_L;
            cnt_d   = bus.dead_time;
          end
        end
        ST_L_ON: begin
          if (pwm_q) begin
            state_d = ST_DT_H;
            cnt_d   = bus.dead_time;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State, counter and outputs registered together from the next-state decode,
  // so the gate pins change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_OFF;
      cnt_q           <= '0;
      out_h_q         <= 1'b0;
      out_l_q         <= 1'b0;
      dt_active_q     <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      out_h_q         <= (state_d == ST_H_ON);
      out_l_q         <= (state_d == ST_L_ON);
      dt_active_q     <= (state_d == ST_DT_H) || (state_d == ST_DT_L);
      fault_latched_q <= (state_d == ST_FAULT);
    end
  end

  assign bus.out_h         = out_h_q;
  assign bus.out_l         = out_l_q;
  assign bus.dt_active     = dt_active_q;
  assign bus.fault_latched = fault_latched_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_iob_pwm_deadtime.sv
// Directed bench for the dead-time gate driver: a per-cycle vector table for
// the basic transitions, then hand-written sequences for fault, enable,
// dead-time reload and asynchronous reset behaviour.
module tb_iob_pwm_deadtime;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         total = 0;
  int         bad   = 0;

  iob_pwm_deadtime_if #(.DT_W(8)) bus ();

  iob_pwm_deadtime #(.DT_W(8), .FLT_SYNC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       pwm;
    logic [7:0] dt;
    logic       exp_h;
    logic       exp_l;
    logic       exp_dt;
    logic       exp_flt;
  } vec_t;

  vec_t vecs[$];

  // Gate overlap check on every cycle of the run.
  always @(negedge clk) begin
    total++;
    if (bus.out_h && bus.out_l) begin
      bad++;
      $display("FAIL overlap: out_h=%0b out_l=%0b required never both 1 (t=%0t)",
               bus.out_h, bus.out_l, $time);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic pwm, input logic [7:0] dt,
                     input logic h, input logic l, input logic d, input logic f);
    vec_t v;
    v.en = en; v.pwm = pwm; v.dt = dt;
    v.exp_h = h; v.exp_l = l; v.exp_dt = d; v.exp_flt = f;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string name, input logic h, input logic l,
                          input logic d, input logic f);
    chk({name, ".out_h"}, int'(bus.out_h), int'(h));
    chk({name, ".out_l"}, int'(bus.out_l), int'(l));
    chk({name, ".dt_active"}, int'(bus.dt_active), int'(d));
    chk({name, ".fault_latched"}, int'(bus.fault_latched), int'(f));
  endtask

  // Step until the chosen side turns on, counting dead-time cycles on the way.
  // After the first dead-time cycle dead_time is switched to new_dt.
  task automatic gap_until(input string name, input bit want_h,
                           input logic [7:0] new_dt, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (bus.dt_active) begin
        n++;
        if (n == 1) bus.dead_time = new_dt;
      end
      if (want_h ? bus.out_h : bus.out_l) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s: output never turned on within 40 cycles", name);
    end
  endtask

  initial begin
    int n;
    int gap;
    int edges;
    bit seen;

    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.pwm_in    = 1'b0;
    bus.dead_time = 8'd0;
    bus.fault_in  = 1'b0;
    bus.fault_clr = 1'b0;

    // Reset values while held in reset
    step();
    step();
    chk_outs("reset", 0, 0, 0, 0);
    rst = 1'b1;

    // Vector table: one entry per clock edge, expectations after that edge.
    //   en pwm dt   h  l  dt flt
    add(0, 0, 8'd3, 0, 0, 0, 0);  // stays OFF while disabled
    add(1, 0, 8'd3, 0, 0, 1, 0);  // OFF -> DT_L, load 3
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 1, 0, 0);  // L_ON after D+1 dead cycles
    add(1, 1, 8'd3, 0, 1, 0, 0);  // E0: pwm captured
    add(1, 1, 8'd3, 0, 0, 1, 0);  // E0+1: out_l falls
    add(1, 1, 8'd3, 0, 0, 1, 0);
    add(1, 1, 8'd3, 0, 0, 1, 0);
    add(1, 1, 8'd3, 0, 0, 1, 0);
    add(1, 1, 8'd3, 1, 0, 0, 0);  // E0+5: out_h rises
    add(1, 1, 8'd3, 1, 0, 0, 0);
    add(1, 0, 8'd3, 1, 0, 0, 0);  // falling edge captured
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 0, 1, 0);
    add(1, 0, 8'd3, 0, 1, 0, 0);  // symmetric 4-cycle gap
    add(1, 1, 8'd0, 0, 1, 0, 0);  // D=0
    add(1, 1, 8'd0, 0, 0, 1, 0);  // single dead cycle
    add(1, 1, 8'd0, 1, 0, 0, 0);
    add(1, 0, 8'd0, 1, 0, 0, 0);
    add(1, 0, 8'd0, 0, 0, 1, 0);
    add(1, 0, 8'd0, 0, 1, 0, 0);
    add(1, 1, 8'd8, 0, 1, 0, 0);  // 4-cycle pulse with D=8
    add(1, 1, 8'd8, 0, 0, 1, 0);
    add(1, 1, 8'd8, 0, 0, 1, 0);
    add(1, 1, 8'd8, 0, 0, 1, 0);
    add(1, 0, 8'd8, 0, 0, 1, 0);
    add(1, 0, 8'd8, 0, 1, 0, 0);  // aborted straight back to L_ON
    add(1, 0, 8'd8, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      bus.en        = vecs[i].en;
      bus.pwm_in    = vecs[i].pwm;
      bus.dead_time = vecs[i].dt;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_h, vecs[i].exp_l,
               vecs[i].exp_dt, vecs[i].exp_flt);
    end

    // Square wave, period 10, D=0: every hand-over shows one both-off cycle.
    bus.dead_time = 8'd0;
    gap   = 0;
    edges = 0;
    for (int c = 0; c < 40; c++) begin
      bus.pwm_in = ((c / 5) % 2 == 0);
      step();
      if (!bus.out_h && !bus.out_l) begin
        gap++;
      end else if (gap != 0) begin
        chk("sq_gap", gap, 1);
        edges++;
        gap = 0;
      end
    end
    chk("sq_edges_seen", int'(edges >= 6), 1);

    // Reach H_ON with D=3, then a 2-cycle fault pulse.
    bus.pwm_in    = 1'b1;
    bus.dead_time = 8'd3;
    gap_until("to_h_on", 1'b1, 8'd3, n);
    chk("pre_fault_h", int'(bus.out_h), 1);
    bus.fault_in = 1'b1;
    step();
    step();
    bus.fault_in = 1'b0;
    step();
    chk_outs("fault_3edges", 0, 0, 0, 1);
    step();
    step();
    chk("fault_held", int'(bus.fault_latched), 1);

    // Clear while fault is still asserted is ignored.
    bus.fault_in = 1'b1;
    step();
    step();
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk("clr_ignored", int'(bus.fault_latched), 1);
    bus.fault_in = 1'b0;
    step();
    step();
    step();
    chk("fault_after_release", int'(bus.fault_latched), 1);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk_outs("clr_to_off", 0, 0, 0, 0);
    gap_until("post_fault", 1'b1, 8'd3, n);
    chk("post_fault_gap", n, 4);

    // Enable dropped mid dead-time, then restored with pwm high.
    bus.pwm_in = 1'b0;
    gap_until("to_l_on", 1'b0, 8'd3, n);
    bus.pwm_in = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      step();
      seen = bus.dt_active;
    end
    chk("dt_h_entered", int'(seen), 1);
    step();
    bus.en = 1'b0;
    step();
    chk_outs("en_drop", 0, 0, 0, 0);
    step();
    bus.en = 1'b1;
    gap_until("en_restore", 1'b1, 8'd3, n);
    chk("en_restore_gap", n, 4);

    // dead_time changed mid-count: current gap keeps 3, next uses 10.
    bus.pwm_in    = 1'b0;
    bus.dead_time = 8'd3;
    gap_until("dt_change_cur", 1'b0, 8'd10, n);
    chk("dt_change_cur_gap", n, 4);
    bus.pwm_in = 1'b1;
    gap_until("dt_change_next", 1'b1, 8'd10, n);
    chk("dt_change_next_gap", n, 11);

    // Asynchronous reset between edges while the low side is on.
    bus.pwm_in = 1'b0;
    gap_until("to_l_on_rst", 1'b0, 8'd10, n);
    chk("pre_rst_l", int'(bus.out_l), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 0);
    bus.en = 1'b0;
    #3;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_outs($sformatf("post_rst%0d", c), 0, 0, 0, 0);
    end
    bus.en = 1'b1;
    step();
    chk_outs("rst_reenable", 0, 0, 1, 0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_pwm_deadtime.md
Name: iob_pwm_deadtime

Overview:
- Downstream stage of the PWM generator.
- Consumes its single-ended PWM output and drives a complementary high-side/low-side gate pair, with programmable dead time between the two.
- Includes a latched fault shutdown.
- Sits between the PWM core and the top-level pads.

Parameters:
DT_W, 8, width of dead-time count; maximum both-off gap is 2^DT_W cycles
FLT_SYNC, 2, number of synchronizer flops on fault_in (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
en  input  1  enable; 0 forces both outputs off
pwm_in  input  1  PWM from the upstream generator, synchronous to clk
dead_time  input  DT_W  dead-time count D, sampled at load only
fault_in  input  1  asynchronous external fault, active-high
fault_clr  input  1  single-cycle pulse; clears a latched fault
out_h  output  1  high-side drive, registered
out_l  output  1  low-side drive, registered
dt_active  output  1  1 while in a dead-time state
fault_latched  output  1  1 while in FAULT

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-low.
- Reset values (rst=0): state OFF, pwm_q=0, counter=0, synchronizer flops=0, all outputs 0.
- pwm_in is registered once into pwm_q. All decisions use pwm_q.
- Outputs are registered from next-state decode:
  - out_h=1 only in H_ON.
  - out_l=1 only in L_ON.
  - dt_active=1 in DT_H and DT_L.
  - fault_latched=1 in FAULT.
- Invariant: out_h and out_l are never 1 in the same cycle, including across reset and fault.
- fault_s is fault_in after FLT_SYNC flops.
- Priority per edge: fault_s, then !en, then normal transitions.
- States and transitions:
  - Any state, fault_s=1 -> FAULT.
  - Any non-FAULT state, en=0 -> OFF.
  - OFF, en=1: pwm_q=1 -> DT_H, else -> DT_L. Counter loads dead_time.
  - DT_H: counter==0 -> H_ON, else counter decrements. If pwm_q=0 during DT_H -> L_ON directly (abort; high side never turned on).
  - DT_L: mirror of DT_H. counter==0 -> L_ON. If pwm_q=1 -> H_ON directly.
  - H_ON: pwm_q=0 -> DT_L, counter loads dead_time.
  - L_ON: pwm_q=1 -> DT_H, counter loads dead_time.
  - FAULT: fault_clr=1 and fault_s=0 -> OFF. fault_clr while fault_s=1 is ignored; the fault stays latched.
- Timing: pwm_in sampled 1 at edge E0, with the block in L_ON.
  - out_l=0 after E0+1.
  - out_h=1 after E0+2+D.
  - Both-off gap is D+1 cycles. D=0 still gives a 1-cycle gap.
  - Falling transition is symmetric.
- Counter behaviour:
  - Counter is DT_W bits, decrements only, never wraps; it stops at 0.
  - dead_time changes mid-count have no effect until the next load.
  - D = all-ones gives a gap of 2^DT_W cycles.
- en deasserted mid-dead-time: OFF next edge, counter value irrelevant.
- en reasserted: a fresh dead time is always inserted before either output turns on.
- PWM pulses shorter than the dead time are absorbed:
  - Pulse ends before DT_H expires -> return to L_ON; out_h never asserts.
- Fault latency: fault_in rising -> outputs 0 within FLT_SYNC+1 edges.
- Fault pulses: any fault_in high pulse of at least 2 clk periods must be latched. Shorter pulses may be missed.
- Reset asserted mid-operation: outputs drop to 0 asynchronously, without waiting for a clock edge.

Test Plan:
- D=3, en=1, pwm_in toggles 0->1 at E0 from settled L_ON -> out_l falls after E0+1; out_h rises after E0+5; exactly 4 cycles with both 0; dt_active high over those cycles.
- D=0, pwm_in square wave of period 10 -> every transition shows exactly one both-off cycle; out_h & out_l never both 1 (assertion across entire run).
- D=8, pwm_in high pulse of 4 cycles from L_ON -> out_h stays 0; out_l returns to 1; no overlap.
- fault_in asserted for 2 cycles while in H_ON -> out_h=0 and fault_latched=1 within 3 edges. fault_clr while fault_in is still high -> remains FAULT. fault_clr after release -> OFF, then a dead time of D+1 cycles before either output turns on.
- en dropped during DT_H, then re-raised with pwm_in=1 -> outputs 0 next edge; on re-raise, full D+1 gap before out_h=1. Also: dead_time changed from 3 to 10 mid-count -> current gap stays 4 cycles; next gap is 11.
- rst pulled low asynchronously between edges while out_l=1 -> out_l=0 immediately; after release, all outputs stay 0 until en=1, and reset values match the spec.
